// File: rtl/cacheline_arbiter_pkg.sv
// Shared types for the L1-to-memory cacheline arbiter and the memory-side line adaptor.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package arbiter_types;

   localparam int LINE_W_DEFAULT = 256;
   localparam int ADDR_W_DEFAULT = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      RECOVER = 2'd3
   } arb_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

endpackage

// File: rtl/cacheline_arbiter_rr_grant2.sv
// Two-input round-robin chooser: picks I or D, alternating when both request.
// Latency: grant is combinational; the last-grant memory updates on the enabled edge.
// Backpressure: none; the caller asserts en only when it actually accepts the grant.
module rr_grant2
   import arbiter_types::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    req_i,
   input  logic    req_d,
   input  logic    en,
   output req_id_t grant
);

   req_id_t last;

   // Solo requester always wins; on contention the side not served last time wins.
   always_comb begin
      grant = REQ_I;
      if (req_i && req_d) begin
         grant = (last == REQ_I) ? REQ_D : REQ_I;
      end else if (req_d) begin
         grant = REQ_D;
      end
   end

   // Remember who was served; reset favours I on the first contended grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         last <= REQ_D;
      end else if (en) begin
         last <= grant;
      end
   end

endmodule

// File: rtl/cacheline_arbiter.sv
// Shares one cacheline memory port between the icache fill path and dcache fill/writeback path.
// Latency: command on mem_* one cycle after grant; resp pulse one cycle after mem_resp.
// Backpressure: requests are level-held until their resp; the loser waits for the next IDLE.
module cacheline_arbiter
   import arbiter_types::*;
#(
   parameter int LINE_W      = LINE_W_DEFAULT,
   parameter int ADDR_W      = ADDR_W_DEFAULT,
   parameter bit STRAY_CHECK = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   arb_state_t state_q;
   arb_state_t state_d;
   req_id_t    grant;
   logic       grant_en;
   logic       i_req;
   logic       d_req;

   assign i_req = i_read;
   assign d_req = d_read | d_write;

   rr_grant2 u_rr (
      .clk   (clk),
      .rst   (rst),
      .req_i (i_req),
      .req_d (d_req),
      .en    (grant_en),
      .grant (grant)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: grant only from IDLE, and always pass through RECOVER after a transfer
   // so a requester is never re-granted while its resp is still visible.
   always_comb begin
      state_d  = state_q;
      grant_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_req || d_req) begin
               grant_en = 1'b1;
               state_d  = (grant == REQ_I) ? SERVE_I : SERVE_D;
            end
         end
         SERVE_I, SERVE_D: begin
            if (mem_resp) begin
               state_d = RECOVER;
            end
         end
         RECOVER: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output registers: latch the granted command, then capture read data and pulse resp.
   // A D request carrying both read and write is issued as a write only.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_resp    <= 1'b0;
         d_resp    <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         i_resp <= 1'b0;
         d_resp <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant_en) begin
                  if (grant == REQ_I) begin
                     mem_read  <= 1'b1;
                     mem_write <= 1'b0;
                     mem_addr  <= i_addr;
                     mem_wdata <= '0;
                  end else begin
                     mem_read  <= ~d_write;
                     mem_write <= d_write;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end
               end
            end
            SERVE_I: begin
               if (mem_resp) begin
                  i_rdata   <= mem_rdata;
                  i_resp    <= 1'b1;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
               end
            end
            SERVE_D: begin
               if (mem_resp) begin
                  d_rdata   <= mem_rdata;
                  d_resp    <= 1'b1;
                  mem_read  <= 1'b0;
                  mem_write <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Protocol checks: exclusive command/resp signalling, illegal D read+write, stray mem_resp.
   always @(posedge clk) begin
      if (!rst) begin
         assert ($onehot0({i_resp, d_resp, mem_read, mem_write}))
            else $error("cacheline_arbiter: overlapping resp/mem command");
         if (STRAY_CHECK) begin
            assert (!(d_read && d_write))
               else $error("cacheline_arbiter: d_read and d_write both asserted");
            assert (!(mem_resp && (state_q == IDLE || state_q == RECOVER)))
               else $error("cacheline_arbiter: mem_resp with no transfer outstanding");
         end
      end
   end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Self-checking bench for cacheline_arbiter: directed scenarios plus randomized traffic.
// Latency: checks command one cycle after grant and resp one cycle after mem_resp.
// Backpressure: requesters hold requests until their resp, as the L1 caches do.
module tb_cacheline_arbiter;

   localparam int LW = 256;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_read;
   logic [AW-1:0] i_addr;
   logic [LW-1:0] i_rdata;
   logic          i_resp;
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_addr;
   logic [LW-1:0] d_wdata;
   logic [LW-1:0] d_rdata;
   logic          d_resp;
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic [LW-1:0] mem_rdata;
   logic          mem_resp;

   logic [4+AW+3*LW-1:0] all_out;
   assign all_out = {mem_read, mem_write, i_resp, d_resp, mem_addr, mem_wdata, i_rdata, d_rdata};

   int checks = 0;
   int errors = 0;
   bit last_d;   // reference model: 1 when the most recent grant went to the dcache side

   typedef struct packed {
      logic          got;
      logic [7:0]    wcyc;
      logic          rd;
      logic          wr;
      logic [AW-1:0] addr;
      logic [LW-1:0] wdata;
      logic          stable;
      logic          excl;
      logic          ir;
      logic          dr;
      logic [LW-1:0] ird;
      logic [LW-1:0] drd;
      logic          cmd_clr;
      logic          ir2;
      logic          dr2;
      logic          held;
   } obs_t;

   always #5 clk = ~clk;

   cacheline_arbiter #(.LINE_W(LW), .ADDR_W(AW), .STRAY_CHECK(1'b0)) dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   // Reference winner: a solo requester wins, contention goes to the side not served last.
   function automatic bit pick_d(input bit ri, input bit rd);
      if (ri && rd) return !last_d;
      return rd;
   endfunction

   task automatic idle_inputs();
      i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
   endtask

   // Plays the memory side for one transfer and records what the arbiter did.
   task automatic do_xfer(input int lat, input logic [LW-1:0] rdat, input bit chg,
                          input logic [AW-1:0] new_iaddr, output obs_t o);
      o = '0;
      for (int k = 0; k < 60 && !o.got; k++) begin
         @(negedge clk);
         if (mem_read || mem_write) begin
            o.got = 1; o.wcyc = 8'(k + 1);
         end
      end
      if (!o.got) return;
      o.rd = mem_read; o.wr = mem_write; o.addr = mem_addr; o.wdata = mem_wdata;
      o.stable = 1;
      o.excl = !(mem_read && mem_write) && !i_resp && !d_resp;
      if (chg) i_addr = new_iaddr;
      for (int k = 0; k < lat; k++) begin
         mem_rdata = rand_line();
         @(negedge clk);
         if (mem_read !== o.rd || mem_write !== o.wr || mem_addr !== o.addr || mem_wdata !== o.wdata)
            o.stable = 0;
         if ((mem_read && mem_write) || i_resp || d_resp) o.excl = 0;
      end
      mem_resp = 1; mem_rdata = rdat;
      @(negedge clk);
      mem_resp = 0; mem_rdata = rand_line();
      o.ir = i_resp; o.dr = d_resp; o.ird = i_rdata; o.drd = d_rdata;
      o.cmd_clr = !mem_read && !mem_write;
      if (i_resp) i_read = 0;
      if (d_resp) begin d_read = 0; d_write = 0; end
      @(negedge clk);
      o.ir2 = i_resp; o.dr2 = d_resp;
      o.held = (i_rdata === o.ird) && (d_rdata === o.drd);
   endtask

   task automatic test_reset();
      rst = 1; idle_inputs();
      i_read = 1; d_write = 1; mem_resp = 1; i_addr = 32'h40; d_addr = 32'h80;
      d_wdata = rand_line(); mem_rdata = rand_line();
      repeat (2) @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL reset_hold got=%h exp=0", all_out); end
      idle_inputs();
      @(negedge clk); rst = 0;
      @(negedge clk);
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL reset_release got=%h exp=0", all_out); end
      last_d = 1;
   endtask

   task automatic test_solo_i();
      obs_t o;
      logic [LW-1:0] a5 = {32{8'hA5}};
      i_read = 1; i_addr = 32'h60;
      do_xfer(3, a5, 0, '0, o);
      last_d = 0;
      checks++;
      if ({o.got, o.wcyc, o.rd, o.wr, o.addr} !== {1'b1, 8'd1, 1'b1, 1'b0, 32'h60}) begin
         errors++; $display("FAIL solo_cmd got=%h exp=%h", {o.got, o.wcyc, o.rd, o.wr, o.addr},
                             {1'b1, 8'd1, 1'b1, 1'b0, 32'h60});
      end
      checks++;
      if ({o.ir, o.dr, o.ir2, o.dr2, o.cmd_clr, o.stable, o.excl} !== 7'b1000111) begin
         errors++; $display("FAIL solo_resp got=%b exp=1000111",
                             {o.ir, o.dr, o.ir2, o.dr2, o.cmd_clr, o.stable, o.excl});
      end
      checks++;
      if (o.ird !== a5) begin errors++; $display("FAIL solo_rdata got=%h exp=%h", o.ird, a5); end
   endtask

   task automatic test_simultaneous();
      obs_t o;
      rst = 1; idle_inputs(); @(negedge clk); rst = 0; last_d = 1;
      i_read = 1; i_addr = 32'h40;
      d_write = 1; d_addr = 32'h100; d_wdata = LW'(32'h1234);
      do_xfer(2, rand_line(), 0, '0, o);
      checks++;
      if ({o.rd, o.wr, o.addr, o.ir, o.dr, o.excl} !== {1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b1}) begin
         errors++; $display("FAIL simul_first got=%h exp=%h", {o.rd, o.wr, o.addr, o.ir, o.dr, o.excl},
                             {1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 1'b1});
      end
      do_xfer(4, rand_line(), 0, '0, o);
      last_d = 1;
      checks++;
      if ({o.rd, o.wr, o.addr, o.dr, o.ir, o.excl, o.cmd_clr} !==
          {1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1}) begin
         errors++; $display("FAIL simul_write got=%h exp=%h", {o.rd, o.wr, o.addr, o.dr, o.ir, o.excl, o.cmd_clr},
                             {1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 1'b1});
      end
      checks++;
      if (o.wdata !== LW'(32'h1234)) begin
         errors++; $display("FAIL simul_wdata got=%h exp=1234", o.wdata);
      end
   endtask

   task automatic test_round_robin();
      obs_t o;
      bit exp_d;
      i_read = 1; i_addr = 32'h2000; d_read = 1; d_addr = 32'h3000;
      for (int t = 0; t < 4; t++) begin
         exp_d = pick_d(1, 1);
         last_d = exp_d;
         do_xfer($urandom_range(1, 4), rand_line(), 0, '0, o);
         checks++;
         if ({o.got, o.dr, o.ir, o.ir2, o.dr2, o.addr} !==
             {1'b1, exp_d, !exp_d, 1'b0, 1'b0, exp_d ? 32'h3000 : 32'h2000}) begin
            errors++; $display("FAIL rr_%0d got=%h exp=%h", t, {o.got, o.dr, o.ir, o.ir2, o.dr2, o.addr},
                                {1'b1, exp_d, !exp_d, 1'b0, 1'b0, exp_d ? 32'h3000 : 32'h2000});
         end
         if (t < 3) begin
            if (exp_d) d_read = 1; else i_read = 1;
         end else begin
            i_read = 0; d_read = 0;
         end
      end
   endtask

   task automatic test_addr_change();
      obs_t o;
      i_read = 1; i_addr = 32'h60;
      do_xfer(5, rand_line(), 1, 32'h80, o);
      last_d = 0;
      checks++;
      if ({o.addr, o.stable, o.ir} !== {32'h60, 1'b1, 1'b1}) begin
         errors++; $display("FAIL addr_hold got=%h exp=%h", {o.addr, o.stable, o.ir}, {32'h60, 1'b1, 1'b1});
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      bit seen = 0;
      logic [LW-1:0] rd = rand_line();
      d_write = 1; d_addr = 32'h200; d_wdata = rand_line();
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         if (mem_write) seen = 1;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL rmid_start got=0 exp=1 (no mem_write)"); end
      @(negedge clk);
      rst = 1; d_write = 0;
      @(negedge clk);
      rst = 0; last_d = 1;
      checks++;
      if (all_out !== '0) begin errors++; $display("FAIL rmid_clear got=%h exp=0", all_out); end
      d_read = 1; d_addr = 32'h220;
      do_xfer(2, rd, 0, '0, o);
      last_d = 1;
      checks++;
      if ({o.wcyc, o.rd, o.wr, o.addr, o.dr, o.ir} !== {8'd1, 1'b1, 1'b0, 32'h220, 1'b1, 1'b0}) begin
         errors++; $display("FAIL rmid_after got=%h exp=%h", {o.wcyc, o.rd, o.wr, o.addr, o.dr, o.ir},
                             {8'd1, 1'b1, 1'b0, 32'h220, 1'b1, 1'b0});
      end
      checks++;
      if (o.drd !== rd) begin errors++; $display("FAIL rmid_rdata got=%h exp=%h", o.drd, rd); end
   endtask

   task automatic test_stray();
      obs_t o;
      d_read = 1; d_write = 1; d_addr = 32'h300; d_wdata = rand_line();
      do_xfer(2, rand_line(), 0, '0, o);
      last_d = 1;
      checks++;
      if ({o.rd, o.wr, o.addr, o.dr, o.dr2} !== {1'b0, 1'b1, 32'h300, 1'b1, 1'b0}) begin
         errors++; $display("FAIL illegal_rw got=%h exp=%h", {o.rd, o.wr, o.addr, o.dr, o.dr2},
                             {1'b0, 1'b1, 32'h300, 1'b1, 1'b0});
      end
      mem_resp = 1; mem_rdata = rand_line();
      @(negedge clk);
      mem_resp = 0;
      checks++;
      if ({i_resp, d_resp, mem_read, mem_write} !== 4'b0) begin
         errors++; $display("FAIL stray_resp got=%b exp=0000", {i_resp, d_resp, mem_read, mem_write});
      end
      i_read = 1; i_addr = 32'h4a0;
      do_xfer(1, rand_line(), 0, '0, o);
      last_d = 0;
      checks++;
      if ({o.wcyc, o.rd, o.addr, o.ir} !== {8'd1, 1'b1, 32'h4a0, 1'b1}) begin
         errors++; $display("FAIL stray_after got=%h exp=%h", {o.wcyc, o.rd, o.addr, o.ir},
                             {8'd1, 1'b1, 32'h4a0, 1'b1});
      end
   endtask

   task automatic test_random();
      obs_t o;
      int pat, n, lat;
      bit ri, dq, dw, first_d, sd;
      logic [AW-1:0] ia, da;
      logic [LW-1:0] dwd, rdat;
      for (int it = 0; it < 24; it++) begin
         pat = $urandom_range(1, 5);
         ri = (pat == 1) || (pat >= 4);
         dq = (pat != 1);
         dw = (pat == 3) || (pat == 5);
         ia = $urandom & ~32'h1f; da = $urandom & ~32'h1f; dwd = rand_line();
         i_read = ri; i_addr = ia; d_read = dq && !dw; d_write = dq && dw; d_addr = da; d_wdata = dwd;
         first_d = pick_d(ri, dq);
         n = (ri && dq) ? 2 : 1;
         for (int t = 0; t < n; t++) begin
            sd = (t == 0) ? first_d : !first_d;
            last_d = sd;
            rdat = rand_line(); lat = $urandom_range(1, 6);
            do_xfer(lat, rdat, 0, '0, o);
            checks++;
            if ({o.got, o.rd, o.wr, o.addr} !== {1'b1, sd ? !dw : 1'b1, sd && dw, sd ? da : ia}) begin
               errors++; $display("FAIL rnd%0d_%0d_cmd got=%h exp=%h", it, t, {o.got, o.rd, o.wr, o.addr},
                                   {1'b1, sd ? !dw : 1'b1, sd && dw, sd ? da : ia});
            end
            checks++;
            if ({o.ir, o.dr, o.ir2, o.dr2, o.cmd_clr, o.stable, o.excl, o.held} !==
                {!sd, sd, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1}) begin
               errors++; $display("FAIL rnd%0d_%0d_resp got=%b exp=%b", it, t,
                                   {o.ir, o.dr, o.ir2, o.dr2, o.cmd_clr, o.stable, o.excl, o.held},
                                   {!sd, sd, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1});
            end
            checks++;
            if ((sd ? o.drd : o.ird) !== rdat) begin
               errors++; $display("FAIL rnd%0d_%0d_rdata got=%h exp=%h", it, t, sd ? o.drd : o.ird, rdat);
            end
            if (sd && dw) begin
               checks++;
               if (o.wdata !== dwd) begin
                  errors++; $display("FAIL rnd%0d_%0d_wdata got=%h exp=%h", it, t, o.wdata, dwd);
               end
            end
         end
      end
   endtask

   initial begin
      rst = 1; idle_inputs();
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      last_d = 1;
      test_reset();
      test_solo_i();
      test_simultaneous();
      test_round_robin();
      test_addr_change();
      test_reset_mid();
      test_stray();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
